// File: rtl/cache_tag_pkg.sv
// cache_tag_pkg: width derivation, flush FSM encoding and {way,set} address helpers
// shared by the L2 tag store and its bench.
`ifndef BW_WORD_ADDR
`define BW_WORD_ADDR 30
`endif
`ifndef BW_BLOCK
`define BW_BLOCK 2
`endif
package cache_tag_pkg;
    localparam int BW_WORD_ADDR = `BW_WORD_ADDR;
    localparam int BW_BLOCK = `BW_BLOCK;

    typedef enum logic [1:0] {IDLE, FLUSH, DONE} flush_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    function automatic int bw_set(input int cap, input int ways);
        return clog2(cap) - clog2(ways);
    endfunction

    function automatic int bw_tag(input int cap, input int ways);
        return BW_WORD_ADDR - bw_set(cap, ways) - BW_BLOCK;
    endfunction

    // block address is {way,set}; with no set bits it degenerates to {way}
    function automatic int add_way(input int add, input int bws);
        return add >> bws;
    endfunction

    function automatic int add_set(input int add, input int bws);
        return add & ((1 << bws) - 1);
    endfunction

    function automatic int pack_add(input int way, input int set, input int bws);
        return (way << bws) | set;
    endfunction
endpackage

// File: rtl/identity_comparator.sv
// identity_comparator: equality compare of two tags.
module identity_comparator #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq
);
    assign eq = (a == b);
endmodule

// File: rtl/way_match_encoder.sv
// way_match_encoder: reduces a per-way match vector to the lowest matching way and a found flag.
module way_match_encoder #(
    parameter int N  = 4,
    parameter int BW = 2
) (
    input  logic [N-1:0]  onehot,
    output logic [BW-1:0] index,
    output logic          found
);
    always_comb begin
        index = '0;
        for (int i = N - 1; i >= 0; i--) index = onehot[i] ? BW'(i) : index;
    end
    assign found = |onehot;
endmodule

// File: rtl/tag_store_assoc_l2.sv
// tag_store_assoc_l2: set-associative L2 tag store with registered lookup, victim-returning fill,
// invalidate, dirty marking and a one-set-per-cycle flush engine.
module tag_store_assoc_l2
    import cache_tag_pkg::*;
#(
    parameter int CACHE_BLOCK_CAPACITY = 128,
    parameter int CACHE_SET_SIZE = 4,
    localparam int BW_CAP = clog2(CACHE_BLOCK_CAPACITY),
    localparam int BW_WAY = clog2(CACHE_SET_SIZE),
    localparam int BW_SET = bw_set(CACHE_BLOCK_CAPACITY, CACHE_SET_SIZE),
    localparam int BW_TAG = bw_tag(CACHE_BLOCK_CAPACITY, CACHE_SET_SIZE),
    localparam int N_SET = 1 << BW_SET,
    localparam int SW = (BW_SET > 0) ? BW_SET : 1,
    localparam int WW = (BW_WAY > 0) ? BW_WAY : 1
) (
    input  logic              clock_i,
    input  logic              resetn_i,
    input  logic              lkp_req_i,
    input  logic [SW-1:0]     lkp_set_i,
    input  logic [BW_TAG-1:0] lkp_tag_i,
    output logic              lkp_valid_o,
    output logic              lkp_hit_o,
    output logic [BW_CAP-1:0] lkp_add_o,
    output logic              lkp_dirty_o,
    input  logic              wr_req_i,
    input  logic [BW_CAP-1:0] wr_add_i,
    input  logic [BW_TAG-1:0] wr_tag_i,
    input  logic              wr_dirty_i,
    output logic              vic_valid_o,
    output logic [BW_TAG-1:0] vic_tag_o,
    output logic              vic_dirty_o,
    input  logic              inv_req_i,
    input  logic [BW_CAP-1:0] inv_add_i,
    input  logic              dset_req_i,
    input  logic [BW_CAP-1:0] dset_add_i,
    input  logic              flush_req_i,
    output logic              ready_o,
    output logic              flush_done_o
);
    logic [BW_TAG-1:0]         tag_q   [N_SET][CACHE_SET_SIZE];
    logic [CACHE_SET_SIZE-1:0] valid_q [N_SET];
    logic [CACHE_SET_SIZE-1:0] dirty_q [N_SET];
    flush_state_t              state;
    logic [SW-1:0]             cnt, lset, wset, iset, ds_set;
    logic [WW-1:0]             wway, iway, ds_way, hit_way;
    logic [CACHE_SET_SIZE-1:0] match;
    logic                      hit, acc, lkp_acc, wr_acc, inv_acc, ds_acc, ds_on_fill;

    assign lset   = (BW_SET == 0) ? '0 : lkp_set_i;
    assign wset   = SW'(add_set(int'(wr_add_i), BW_SET));
    assign wway   = WW'(add_way(int'(wr_add_i), BW_SET));
    assign iset   = SW'(add_set(int'(inv_add_i), BW_SET));
    assign iway   = WW'(add_way(int'(inv_add_i), BW_SET));
    assign ds_set = SW'(add_set(int'(dset_add_i), BW_SET));
    assign ds_way = WW'(add_way(int'(dset_add_i), BW_SET));

    // ready_o is high exactly in IDLE, so it doubles as the request gate
    assign acc        = ready_o;
    assign lkp_acc    = acc & lkp_req_i;
    assign wr_acc     = acc & wr_req_i;
    assign inv_acc    = acc & inv_req_i;
    assign ds_acc     = acc & dset_req_i & valid_q[ds_set][ds_way];
    assign ds_on_fill = dset_req_i & (dset_add_i == wr_add_i);

    for (genvar w = 0; w < CACHE_SET_SIZE; w++) begin : g_way
        logic eq;
        identity_comparator #(.WIDTH(BW_TAG)) u_cmp (
            .a (tag_q[lset][w]),
            .b (lkp_tag_i),
            .eq(eq)
        );
        assign match[w] = eq & valid_q[lset][w];
    end

    way_match_encoder #(.N(CACHE_SET_SIZE), .BW(WW)) u_enc (
        .onehot(match),
        .index (hit_way),
        .found (hit)
    );

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            lkp_valid_o <= 1'b0;
            lkp_hit_o   <= 1'b0;
            lkp_add_o   <= '0;
            lkp_dirty_o <= 1'b0;
            vic_valid_o <= 1'b0;
            vic_tag_o   <= '0;
            vic_dirty_o <= 1'b0;
        end else begin
            lkp_valid_o <= lkp_acc;
            if (lkp_acc) begin
                lkp_hit_o   <= hit;
                lkp_add_o   <= hit ? BW_CAP'(pack_add(int'(hit_way), int'(lset), BW_SET)) : '0;
                lkp_dirty_o <= hit & dirty_q[lset][hit_way];
            end
            vic_valid_o <= wr_acc & valid_q[wset][wway];
            if (wr_acc) begin
                vic_tag_o   <= tag_q[wset][wway];
                vic_dirty_o <= dirty_q[wset][wway];
            end
        end
    end

    // later assignments win: fill overrides invalidate and dirty-set on the same entry
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int s = 0; s < N_SET; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < CACHE_SET_SIZE; w++) tag_q[s][w] <= '0;
            end
        end else begin
            if (state == FLUSH) begin
                valid_q[cnt] <= '0;
                dirty_q[cnt] <= '0;
            end
            if (inv_acc) begin
                valid_q[iset][iway] <= 1'b0;
                dirty_q[iset][iway] <= 1'b0;
            end
            if (ds_acc) dirty_q[ds_set][ds_way] <= 1'b1;
            if (wr_acc) begin
                tag_q[wset][wway]   <= wr_tag_i;
                valid_q[wset][wway] <= 1'b1;
                dirty_q[wset][wway] <= wr_dirty_i | ds_on_fill;
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state        <= IDLE;
            cnt          <= '0;
            ready_o      <= 1'b1;
            flush_done_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (flush_req_i) begin
                    state   <= FLUSH;
                    cnt     <= '0;
                    ready_o <= 1'b0;
                end
                FLUSH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == SW'(N_SET - 1)) begin
                        state        <= DONE;
                        flush_done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    flush_done_o <= 1'b0;
                    ready_o      <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tag_store_assoc_l2.sv
// tb_tag_store_assoc_l2: scoreboard bench for the default 32x4 tag store plus a directed
// fully-associative (128-way) build.
module tb_tag_store_assoc_l2;
    localparam int NS = 32, NW = 4, TW = 23, AW = 7, BT = 28;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          lkp_req, lkp_valid, lkp_hit, lkp_dirty, wr_req, wr_dirty, vic_valid, vic_dirty;
    logic          inv_req, dset_req, flush_req, ready, flush_done;
    logic [4:0]    lkp_set;
    logic [TW-1:0] lkp_tag, wr_tag, vic_tag;
    logic [AW-1:0] lkp_add, wr_add, inv_add, dset_add;

    logic          b_lkp_req, b_lkp_valid, b_lkp_hit, b_lkp_dirty, b_wr_req, b_wr_dirty, b_vic_valid;
    logic          b_vic_dirty, b_inv_req, b_dset_req, b_flush_req, b_ready, b_flush_done;
    logic [0:0]    b_lkp_set;
    logic [BT-1:0] b_lkp_tag, b_wr_tag, b_vic_tag;
    logic [AW-1:0] b_lkp_add, b_wr_add, b_inv_add, b_dset_add;

    tag_store_assoc_l2 dut (
        .clock_i(clk), .resetn_i(rst_n),
        .lkp_req_i(lkp_req), .lkp_set_i(lkp_set), .lkp_tag_i(lkp_tag),
        .lkp_valid_o(lkp_valid), .lkp_hit_o(lkp_hit), .lkp_add_o(lkp_add), .lkp_dirty_o(lkp_dirty),
        .wr_req_i(wr_req), .wr_add_i(wr_add), .wr_tag_i(wr_tag), .wr_dirty_i(wr_dirty),
        .vic_valid_o(vic_valid), .vic_tag_o(vic_tag), .vic_dirty_o(vic_dirty),
        .inv_req_i(inv_req), .inv_add_i(inv_add), .dset_req_i(dset_req), .dset_add_i(dset_add),
        .flush_req_i(flush_req), .ready_o(ready), .flush_done_o(flush_done)
    );

    tag_store_assoc_l2 #(.CACHE_BLOCK_CAPACITY(128), .CACHE_SET_SIZE(128)) dut_fa (
        .clock_i(clk), .resetn_i(rst_n),
        .lkp_req_i(b_lkp_req), .lkp_set_i(b_lkp_set), .lkp_tag_i(b_lkp_tag),
        .lkp_valid_o(b_lkp_valid), .lkp_hit_o(b_lkp_hit), .lkp_add_o(b_lkp_add), .lkp_dirty_o(b_lkp_dirty),
        .wr_req_i(b_wr_req), .wr_add_i(b_wr_add), .wr_tag_i(b_wr_tag), .wr_dirty_i(b_wr_dirty),
        .vic_valid_o(b_vic_valid), .vic_tag_o(b_vic_tag), .vic_dirty_o(b_vic_dirty),
        .inv_req_i(b_inv_req), .inv_add_i(b_inv_add), .dset_req_i(b_dset_req), .dset_add_i(b_dset_add),
        .flush_req_i(b_flush_req), .ready_o(b_ready), .flush_done_o(b_flush_done)
    );

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, longint unsigned act, longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {int due; bit hit; int add; bit dirty;} lkp_exp_t;
    typedef struct {int due; bit v; logic [TW-1:0] tag; bit d;} vic_exp_t;
    lkp_exp_t lq[$];
    vic_exp_t vq[$];

    // reference model: plain per-entry state indexed [set][way]
    bit            m_v   [NS][NW];
    bit            m_d   [NS][NW];
    logic [TW-1:0] m_tag [NS][NW];
    bit            busy;

    always @(negedge clk) begin
        if (rst_n) begin
            bit le, ve;
            le = lq.size() > 0 && lq[0].due == cyc;
            ve = vq.size() > 0 && vq[0].due == cyc;
            check("lkp_valid", lkp_valid, le);
            if (le) begin
                lkp_exp_t e;
                e = lq.pop_front();
                check("lkp_hit", lkp_hit, e.hit);
                check("lkp_add", lkp_add, e.add);
                if (e.hit) check("lkp_dirty", lkp_dirty, e.dirty);
            end
            if (ve) begin
                vic_exp_t e;
                e = vq.pop_front();
                check("vic_valid", vic_valid, e.v);
                if (e.v) begin
                    check("vic_tag", vic_tag, e.tag);
                    check("vic_dirty", vic_dirty, e.d);
                end
            end else check("vic_idle", vic_valid, 0);
        end
    end

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                m_v[s][w] = 0;
                m_d[s][w] = 0;
                m_tag[s][w] = '0;
            end
    endtask

    task automatic model_step();
        int ws, ww, ds, dw;
        bit dv;
        ws = int'(wr_add) % NS; ww = int'(wr_add) / NS;
        ds = int'(dset_add) % NS; dw = int'(dset_add) / NS;
        if (lkp_req) begin
            lkp_exp_t e;
            e = '{cyc + 1, 1'b0, 0, 1'b0};
            for (int w = 0; w < NW; w++)
                if (!e.hit && m_v[lkp_set][w] && m_tag[lkp_set][w] == lkp_tag) begin
                    e.hit = 1;
                    e.add = w * NS + int'(lkp_set);
                    e.dirty = m_d[lkp_set][w];
                end
            lq.push_back(e);
        end
        dv = dset_req && m_v[ds][dw];
        if (wr_req) vq.push_back('{cyc + 1, m_v[ws][ww], m_tag[ws][ww], m_d[ws][ww]});
        if (inv_req) begin
            m_v[int'(inv_add) % NS][int'(inv_add) / NS] = 0;
            m_d[int'(inv_add) % NS][int'(inv_add) / NS] = 0;
        end
        if (dv) m_d[ds][dw] = 1;
        if (wr_req) begin
            m_tag[ws][ww] = wr_tag;
            m_v[ws][ww] = 1;
            m_d[ws][ww] = wr_dirty || (dset_req && dset_add == wr_add);
        end
    endtask

    task automatic clear_reqs();
        lkp_req = 0; wr_req = 0; inv_req = 0; dset_req = 0; flush_req = 0;
    endtask

    task automatic tick();
        if (!busy) model_step();
        @(negedge clk);
        clear_reqs();
    endtask

    function automatic logic [AW-1:0] rand_add(bit narrow);
        int s, w;
        s = narrow ? $urandom_range(0, 3) : $urandom_range(0, NS - 1);
        w = $urandom_range(0, NW - 1);
        return AW'(w * NS + s);
    endfunction

    task automatic rand_reqs(bit narrow);
        lkp_req  = 1'($urandom_range(0, 1));
        lkp_set  = 5'(narrow ? $urandom_range(0, 3) : $urandom_range(0, NS - 1));
        lkp_tag  = TW'($urandom_range(0, 7));
        wr_req   = ($urandom_range(0, 2) == 0);
        wr_add   = rand_add(narrow);
        wr_tag   = TW'($urandom_range(0, 7));
        wr_dirty = 1'($urandom_range(0, 1));
        inv_req  = ($urandom_range(0, 5) == 0);
        inv_add  = rand_add(narrow);
        dset_req = ($urandom_range(0, 3) == 0);
        dset_add = rand_add(narrow);
        if (dset_req && inv_req && dset_add == inv_add) dset_req = 0;
    endtask

    task automatic lookup(int set, int tag);
        lkp_req = 1; lkp_set = 5'(set); lkp_tag = TW'(tag);
        tick();
    endtask

    task automatic fill(int add, int tag, bit d);
        wr_req = 1; wr_add = AW'(add); wr_tag = TW'(tag); wr_dirty = d;
        tick();
    endtask

    task automatic b_clear();
        b_lkp_req = 0; b_wr_req = 0; b_inv_req = 0; b_dset_req = 0; b_flush_req = 0;
    endtask

    int fadd[8];
    int ftag[8];
    int n, done_at, pulses;

    initial begin
        rst_n = 0; busy = 0;
        clear_reqs(); b_clear();
        lkp_set = '0; lkp_tag = '0; wr_add = '0; wr_tag = '0; wr_dirty = 0; inv_add = '0; dset_add = '0;
        b_lkp_set = '0; b_lkp_tag = '0; b_wr_add = '0; b_wr_tag = '0; b_wr_dirty = 0; b_inv_add = '0; b_dset_add = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        check("rst_lkp_valid", lkp_valid, 0); check("rst_lkp_hit", lkp_hit, 0);
        check("rst_lkp_add", lkp_add, 0);     check("rst_lkp_dirty", lkp_dirty, 0);
        check("rst_vic_valid", vic_valid, 0); check("rst_vic_tag", vic_tag, 0);
        check("rst_vic_dirty", vic_dirty, 0); check("rst_ready", ready, 1);
        check("rst_flush_done", flush_done, 0); check("rst_b_ready", b_ready, 1);

        lookup(5, 'h1A3);
        check("cold_valid", lkp_valid, 1); check("cold_hit", lkp_hit, 0); check("cold_add", lkp_add, 0);
        fill(2 * NS + 5, 'h1A3, 0);
        lookup(5, 'h1A3);
        check("fill_hit", lkp_hit, 1); check("fill_add", lkp_add, 'h45); check("fill_dirty", lkp_dirty, 0);
        dset_req = 1; dset_add = AW'(2 * NS + 5); tick();
        lookup(5, 'h1A3);
        check("dset_dirty", lkp_dirty, 1);
        fill(2 * NS + 5, 'h0FF, 0);
        check("refill_vic_valid", vic_valid, 1); check("refill_vic_tag", vic_tag, 'h1A3);
        check("refill_vic_dirty", vic_dirty, 1);
        lookup(5, 'h1A3);
        check("old_tag_miss", lkp_hit, 0);

        wr_req = 1; wr_add = AW'(NS + 7); wr_tag = TW'('h10); wr_dirty = 0;
        lkp_req = 1; lkp_set = 5'd7; lkp_tag = TW'('h10); tick();
        check("same_cycle_miss", lkp_hit, 0);
        lookup(7, 'h10);
        check("next_cycle_hit", lkp_hit, 1); check("next_cycle_add", lkp_add, 'h27);
        wr_req = 1; wr_add = AW'(NS + 7); wr_tag = TW'('h10); inv_req = 1; inv_add = AW'(NS + 7); tick();
        lookup(7, 'h10);
        check("fill_beats_inv", lkp_hit, 1);

        for (int i = 0; i < 600; i++) begin
            rand_reqs(i < 500);
            tick();
        end

        for (int i = 0; i < 8; i++) begin
            fadd[i] = int'(rand_add(0)); ftag[i] = 'h100 + i;
            fill(fadd[i], ftag[i], 1'($urandom_range(0, 1)));
        end
        flush_req = 1; tick();
        busy = 1; model_reset();
        for (int i = 1; i <= 33; i++) begin
            check("flush_ready_low", ready, 0);
            check("flush_done_pulse", flush_done, i == 33);
            rand_reqs(1);
            tick();
        end
        busy = 0;
        check("flush_ready_back", ready, 1); check("flush_done_clear", flush_done, 0);
        for (int i = 0; i < 8; i++) begin
            lookup(fadd[i] % NS, ftag[i]);
            check("post_flush_miss", lkp_hit, 0);
        end

        for (int i = 0; i < 8; i++) fill(fadd[i], ftag[i], 1);
        flush_req = 1; tick();
        busy = 1;
        repeat (10) tick();
        rst_n = 0;
        @(negedge clk);
        check("rst_mid_done", flush_done, 0);
        rst_n = 1; busy = 0; model_reset();
        check("rst_mid_ready", ready, 1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (flush_done) pulses++;
            if (i < 8) lookup(fadd[i] % NS, ftag[i]); else tick();
        end
        check("rst_mid_no_done", pulses, 0);

        b_wr_req = 1; b_wr_add = 7'd100; b_wr_tag = BT'('h123); b_wr_dirty = 1;
        @(negedge clk); b_clear();
        check("fa_vic_empty", b_vic_valid, 0);
        b_wr_req = 1; b_wr_add = 7'd5; b_wr_tag = BT'('h123); b_wr_dirty = 0;
        @(negedge clk); b_clear();
        b_lkp_req = 1; b_lkp_tag = BT'('h123);
        @(negedge clk); b_clear();
        check("fa_valid", b_lkp_valid, 1); check("fa_hit", b_lkp_hit, 1);
        check("fa_lowest_way", b_lkp_add, 5); check("fa_dirty", b_lkp_dirty, 0);
        b_wr_req = 1; b_wr_add = 7'd5; b_wr_tag = BT'('h77); b_wr_dirty = 0;
        @(negedge clk); b_clear();
        check("fa_vic_valid", b_vic_valid, 1); check("fa_vic_tag", b_vic_tag, 'h123);
        b_lkp_req = 1; b_lkp_tag = BT'('h123);
        @(negedge clk); b_clear();
        check("fa_hit2_add", b_lkp_add, 100); check("fa_hit2_dirty", b_lkp_dirty, 1);
        b_flush_req = 1;
        @(negedge clk); b_clear();
        n = 0; done_at = 0;
        while (!b_ready && n < 20) begin
            n++;
            if (b_flush_done) done_at = n;
            @(negedge clk);
        end
        check("fa_flush_cycles", n, 2); check("fa_flush_done_at", done_at, 2);
        b_lkp_req = 1; b_lkp_tag = BT'('h123);
        @(negedge clk); b_clear();
        check("fa_post_flush_miss", b_lkp_hit, 0);

        repeat (3) tick();
        check("lkp_queue_drained", lq.size(), 0);
        check("vic_queue_drained", vq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
